// File: rtl/load_store_unit.sv
// load_store_unit: turns one CPU load/store into memory_unit req/ack transactions, with sub-word RMW stores.
// Optional LSU_TIMEOUT_EN adds a WAIT-state watchdog that finishes the request with err 11.
module load_store_unit #(
  parameter int MEM_BYTES      = 4096,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cpu_valid,
  input  logic        i_cpu_we,
  input  logic [1:0]  i_cpu_size,
  input  logic        i_cpu_unsigned,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic        o_cpu_busy,
  output logic        o_cpu_done,
  output logic [1:0]  o_cpu_err,
  output logic [31:0] o_cpu_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;
  state_t      r_state, w_next;
  logic        r_we, r_uns;
  logic [1:0]  r_size, r_err;
  logic [31:0] r_addr, r_wdata, r_mwdata, r_rdata;
  logic        w_mis, w_rng, w_wait, w_tmo;
  logic [4:0]  w_amt;
  logic [31:0] w_sh, w_ext, w_mask, w_merge;
  assign w_mis  = (i_cpu_size == 2'b01 && i_cpu_addr[0]) || (i_cpu_size[1] && i_cpu_addr[1:0] != 2'b00);
  assign w_rng  = i_cpu_addr >= 32'(MEM_BYTES);
  assign w_wait = r_state == RD_WAIT || r_state == WR_WAIT;
  // Half lanes are selected by addr[1] only; byte lanes by addr[1:0].
  assign w_amt   = r_size[0] ? {r_addr[1], 4'b0000} : {r_addr[1:0], 3'b000};
  assign w_sh    = i_mem_rdata >> w_amt;
  assign w_ext   = r_size[1] ? i_mem_rdata :
                   r_size[0] ? {{16{~r_uns & w_sh[15]}}, w_sh[15:0]} :
                               {{24{~r_uns & w_sh[7]}}, w_sh[7:0]};
  assign w_mask  = (r_size[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_amt;
  assign w_merge = (i_mem_rdata & ~w_mask) | ((r_wdata << w_amt) & w_mask);
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (!w_wait) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end
  assign w_tmo = w_wait && !i_mem_ack && r_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign w_tmo = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_cpu_valid) w_next = (w_mis || w_rng) ? DONE :
                                         (!i_cpu_we || !i_cpu_size[1]) ? RD_REQ : WR_REQ;
      RD_REQ:  w_next = RD_WAIT;
      RD_WAIT: w_next = i_mem_ack ? (r_we ? WR_REQ : DONE) : w_tmo ? DONE : RD_WAIT;
      WR_REQ:  w_next = WR_WAIT;
      WR_WAIT: w_next = (i_mem_ack || w_tmo) ? DONE : WR_WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_uns    <= 1'b0;
      r_size   <= 2'b00;
      r_err    <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_mwdata <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_cpu_valid) begin
        r_we     <= i_cpu_we;
        r_uns    <= i_cpu_unsigned;
        r_size   <= i_cpu_size;
        r_addr   <= i_cpu_addr;
        r_wdata  <= i_cpu_wdata;
        r_mwdata <= i_cpu_wdata;
        r_err    <= w_mis ? 2'b01 : w_rng ? 2'b10 : 2'b00;
      end
      if (r_state == RD_WAIT && i_mem_ack) begin
        if (r_we) r_mwdata <= w_merge;
        else r_rdata <= w_ext;
      end
      if (w_tmo) r_err <= 2'b11;
    end
  end
  assign o_cpu_busy  = r_state != IDLE;
  assign o_cpu_done  = r_state == DONE;
  assign o_cpu_err   = o_cpu_done ? r_err : 2'b00;
  assign o_cpu_rdata = r_rdata;
  assign o_mem_req   = r_state == RD_REQ || r_state == WR_REQ;
  assign o_mem_we    = r_state == WR_REQ;
  assign o_mem_addr  = {r_addr[31:2], 2'b00};
  assign o_mem_wdata = r_mwdata;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed checks of load_store_unit against a 1-cycle memory model.
module tb_load_store_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cpu_valid = 1'b0, cpu_we = 1'b0, cpu_unsigned = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_busy, cpu_done, mem_req, mem_we, mem_ack;
  logic [1:0]  cpu_err;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic        ack_r = 1'b0, ack_en = 1'b1, stray = 1'b0;
  logic [31:0] rd_r = '0;
  logic [31:0] mem [1024];
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  assign mem_ack = ack_r | stray;

  always @(posedge clk) begin
    ack_r <= 1'b0;
    if (mem_req && ack_en) begin
      ack_r <= 1'b1;
      rd_r  <= mem[mem_addr[11:2]];
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_valid(cpu_valid), .i_cpu_we(cpu_we), .i_cpu_size(cpu_size),
    .i_cpu_unsigned(cpu_unsigned), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_busy(cpu_busy), .o_cpu_done(cpu_done), .o_cpu_err(cpu_err), .o_cpu_rdata(cpu_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(rd_r)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  err;
    int          lat;
    int          reqs;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
    cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    #1;
    cpu_valid = 1'b0; cpu_we = ~we; cpu_size = ~size;
    cpu_addr = $urandom; cpu_wdata = $urandom;
  endtask

  // Latency counts the accept edge as 1; returns 40 when cpu_done never rises.
  task automatic run(input vec_t v);
    int lat, reqs;
    issue(v.we, v.size, v.uns, v.addr, v.wdata);
    lat = 1; reqs = 0;
    while (!cpu_done && lat < 40) begin
      if (mem_req) reqs++;
      @(posedge clk); #1 lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " err"}, {30'd0, cpu_err}, {30'd0, v.err});
    check({v.name, " mem_req count"}, 32'(reqs), 32'(v.reqs));
    if (v.we && v.err == 2'b00) check({v.name, " memory word"}, mem[v.addr[11:2]], v.exp);
    else check({v.name, " rdata"}, cpu_rdata, v.exp);
    @(posedge clk); #1;
    check({v.name, " idle after done"}, {30'd0, cpu_busy, cpu_done}, 32'd0);
  endtask

  vec_t vt [$];

  initial begin
    vt.push_back('{"SW 10",   1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 2'b00, 3, 1, 32'hDEADBEEF});
    vt.push_back('{"LW 10",   0, 2'b10, 0, 32'h10,   32'h0,        2'b00, 3, 1, 32'hDEADBEEF});
    vt.push_back('{"SW 10b",  1, 2'b10, 0, 32'h10,   32'h8070F0A5, 2'b00, 3, 1, 32'h8070F0A5});
    vt.push_back('{"LB 13",   0, 2'b00, 0, 32'h13,   32'h0,        2'b00, 3, 1, 32'hFFFFFF80});
    vt.push_back('{"LBU 12",  0, 2'b00, 1, 32'h12,   32'h0,        2'b00, 3, 1, 32'h00000070});
    vt.push_back('{"LH 10",   0, 2'b01, 0, 32'h10,   32'h0,        2'b00, 3, 1, 32'hFFFFF0A5});
    vt.push_back('{"LHU 12",  0, 2'b01, 1, 32'h12,   32'h0,        2'b00, 3, 1, 32'h00008070});
    vt.push_back('{"SW 14",   1, 2'b10, 0, 32'h14,   32'h11223344, 2'b00, 3, 1, 32'h11223344});
    vt.push_back('{"SB 15",   1, 2'b00, 0, 32'h15,   32'h000000CC, 2'b00, 5, 2, 32'h1122CC44});
    vt.push_back('{"SH 16",   1, 2'b01, 0, 32'h16,   32'h0000BEEF, 2'b00, 5, 2, 32'hBEEFCC44});
    vt.push_back('{"LW 14",   0, 2'b10, 0, 32'h14,   32'h0,        2'b00, 3, 1, 32'hBEEFCC44});
    vt.push_back('{"LB 17",   0, 2'b00, 0, 32'h17,   32'h0,        2'b00, 3, 1, 32'hFFFFFFBE});
    vt.push_back('{"LH 21",   0, 2'b01, 0, 32'h21,   32'h0,        2'b01, 1, 0, 32'hFFFFFFBE});
    vt.push_back('{"LW 1000", 0, 2'b10, 0, 32'h1000, 32'h0,        2'b10, 1, 0, 32'hFFFFFFBE});
    vt.push_back('{"SW 1002", 1, 2'b10, 0, 32'h1002, 32'h5,        2'b01, 1, 0, 32'hFFFFFFBE});
    vt.push_back('{"SW3 FFC", 1, 2'b11, 0, 32'hFFC,  32'h12345678, 2'b00, 3, 1, 32'h12345678});
    vt.push_back('{"LW3 FFC", 0, 2'b11, 1, 32'hFFC,  32'h0,        2'b00, 3, 1, 32'h12345678});

    #12;
    check("reset outputs", {cpu_busy, cpu_done, cpu_err, mem_req, mem_we, 26'd0} | cpu_rdata | mem_addr | mem_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    stray = 1'b1; @(negedge clk); stray = 1'b0;
    @(negedge clk);
    check("stray ack in idle", {29'd0, cpu_busy, cpu_done, mem_req}, 32'd0);

    foreach (vt[i]) run(vt[i]);

    // Reset while the SB read is outstanding: the RMW write must never happen.
    issue(1'b1, 2'b00, 1'b0, 32'h15, 32'h00000055);
    @(posedge clk); #1;
    check("SB in RD_WAIT busy", {31'd0, cpu_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-op reset outputs", {cpu_busy, cpu_done, cpu_err, mem_req, mem_we, 26'd0} | cpu_rdata | mem_addr | mem_wdata, 32'd0);
    begin
      int dones = 0;
      for (int k = 0; k < 4; k++) begin @(posedge clk); #1 if (cpu_done) dones++; end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin @(posedge clk); #1 if (cpu_done || cpu_busy) dones++; end
      check("no done after reset", 32'(dones), 32'd0);
    end
    check("word kept after abort", mem[5], 32'hBEEFCC44);
    run('{"LW after reset", 0, 2'b10, 0, 32'h14, 32'h0, 2'b00, 3, 1, 32'hBEEFCC44});

    // Valid held high across a busy load must not start a second access.
    begin
      int reqs = 0;
      @(negedge clk);
      cpu_valid = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h10;
      for (int k = 0; k < 4; k++) begin @(posedge clk); #1 if (mem_req) reqs++; end
      cpu_valid = 1'b0;
      check("valid while busy ignored", 32'(reqs), 32'd1);
      repeat (3) @(posedge clk);
    end

    // Memory never acknowledges.
    ack_en = 1'b0;
    begin
      int lat = 1;
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      while (!cpu_done && lat < 40) begin @(posedge clk); #1 lat++; end
`ifdef LSU_TIMEOUT_EN
      check("timeout latency", 32'(lat), 32'd18);
      check("timeout err", {30'd0, cpu_err}, 32'd3);
      check("timeout rdata kept", cpu_rdata, 32'h8070F0A5);
`else
      check("no-ack done never", 32'(lat), 32'd40);
      check("no-ack still busy", {31'd0, cpu_busy}, 32'd1);
`endif
    end
    ack_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
